alu_base_arbiter: RTL and testbench

//  Shares one alu_base instance between NUM_REQ requesters (issue ports / test masters).

---
 rtl/alu_base_arbiter.sv | 118 +++++++++++
 tb/tb_alu_base_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_base_arbiter.sv
// Round-robin arbiter sharing one registered-output alu_base among NUM_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module alu_base_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_funct3,
  input  logic [32*NUM_REQ-1:0]   req_rs1,
  input  logic [32*NUM_REQ-1:0]   req_rs2,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_value,
  output logic                    alu_enable,
  output logic [2:0]              alu_funct3,
  output logic [31:0]             alu_rs1,
  output logic [31:0]             alu_rs2,
  input  logic [31:0]             alu_rd,
  output logic                    busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [GW-1:0]     r_last_grant;
  logic [2:0]        r_funct3;
  logic [31:0]       r_rs1;
  logic [31:0]       r_rs2;
  logic [31:0]       r_result;

  logic [GW-1:0]     w_grant;
  logic [GW-1:0]     w_idx;
  logic              w_found;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [NUM_REQ-1:0] w_last_oh;

  logic [2:0]        w_funct3_arr [NUM_REQ];
  logic [31:0]       w_rs1_arr    [NUM_REQ];
  logic [31:0]       w_rs2_arr    [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_funct3_arr[i] = req_funct3[3*i +: 3];
    assign w_rs1_arr[i]    = req_rs1[32*i +: 32];
    assign w_rs2_arr[i]    = req_rs2[32*i +: 32];
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = GW'((int'(r_last_grant) + off) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    w_grant_oh[w_grant] = 1'b1;
    w_last_oh = '0;
    w_last_oh[r_last_grant] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_funct3     <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_last_grant <= w_grant;
        r_funct3     <= w_funct3_arr[w_grant];
        r_rs1        <= w_rs1_arr[w_grant];
        r_rs2        <= w_rs2_arr[w_grant];
      end
      // alu_base drives a valid value only in the cycle after its enable.
      if (r_state == S_WAIT) begin
        r_result <= alu_rd;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  if (rsp_ready[r_last_grant]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (reset_n && r_state == S_IDLE && w_found) ? w_grant_oh : '0;
    rsp_valid  = (r_state == S_RESP) ? w_last_oh : '0;
    alu_enable = (r_state == S_ISSUE);
    busy       = (r_state != S_IDLE);
    rsp_value  = r_result;
    alu_funct3 = r_funct3;
    alu_rs1    = r_rs1;
    alu_rs2    = r_rs2;
  end

endmodule

// File: tb/tb_alu_base_arbiter.sv
// Directed bench for alu_base_arbiter with a behavioural registered-output alu_base.
module tb_alu_base_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [5:0]  req_funct3 = '0;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_value;
  logic        alu_enable;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  wire  [31:0] alu_rd;
  logic        busy;

  int assertCount = 0;
  int failCount = 0;

  alu_base_arbiter #(.NUM_REQ(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value),
    .alu_enable(alu_enable), .alu_funct3(alu_funct3),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd), .busy(busy)
  );

  always #5 clock = ~clock;

  // alu_base stand-in: result registered on an enabled edge, driven only the following cycle.
  logic [31:0] aluReg = '0;
  logic        aluOe = 1'b0;

  function automatic logic [31:0] aluCompute(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(posedge clock) begin
    aluOe <= alu_enable;
    if (alu_enable) aluReg <= aluCompute(alu_funct3, alu_rs1, alu_rs2);
  end

  assign alu_rd = aluOe ? aluReg : 32'hzzzz_zzzz;

  typedef struct {
    logic [1:0]  mask;
    logic [2:0]  f0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  f1;
    logic [31:0] a1;
    logic [31:0] b1;
    int          expG;
    logic [31:0] expV;
    int          delay;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.mask;
    req_funct3 = {v.f1, v.f0};
    req_rs1    = {v.a1, v.a0};
    req_rs2    = {v.b1, v.b0};
    rsp_ready  = '0;
  endtask

  // Waits for the grant, then follows the op through ISSUE, WAIT and RESP, holding
  // the granted rsp_ready low for 'delay' RESP cycles. Returns one tick after the
  // edge that leaves RESP.
  task automatic runTxn(input string tag, input int g, input logic [31:0] expV,
                        input logic [31:0] expRs1, input int delay);
    logic [1:0] oh;
    bit found;
    oh = (g == 0) ? 2'b01 : 2'b10;
    rsp_ready = (delay == 0) ? 2'b11 : ~oh;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (|req_ready) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checkOutput({tag, " grant timeout"}, {30'd0, req_ready}, {30'd0, oh});
      return;
    end
    checkOutput({tag, " req_ready"}, {30'd0, req_ready}, {30'd0, oh});
    @(negedge clock);
    checkOutput({tag, " issue alu_enable"}, {31'd0, alu_enable}, 32'd1);
    checkOutput({tag, " issue alu_rs1"}, alu_rs1, expRs1);
    checkOutput({tag, " issue req_ready"}, {30'd0, req_ready}, 32'd0);
    @(negedge clock);
    checkOutput({tag, " wait alu_enable"}, {31'd0, alu_enable}, 32'd0);
    checkOutput({tag, " wait rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    @(negedge clock);
    checkOutput({tag, " rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh});
    checkOutput({tag, " rsp_value"}, rsp_value, expV);
    for (int k = 1; k < delay; k++) begin
      @(negedge clock);
      checkOutput($sformatf("%s hold%0d rsp_valid", tag, k), {30'd0, rsp_valid}, {30'd0, oh});
      checkOutput($sformatf("%s hold%0d rsp_value", tag, k), rsp_value, expV);
      checkOutput($sformatf("%s hold%0d req_ready", tag, k), {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 2'b11;
    @(posedge clock);
    #1;
    checkOutput({tag, " done busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " done rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    vec_t v;
    // Alternating grants while both requesters hold SLT / SLTU valid.
    vecs[0] = '{2'b11, 3'd2, 32'hFFFF_FFFF, 32'd1, 3'd3, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 0};
    vecs[1] = '{2'b11, 3'd2, 32'hFFFF_FFFF, 32'd1, 3'd3, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0};
    vecs[2] = '{2'b11, 3'd2, 32'hFFFF_FFFF, 32'd1, 3'd3, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 0};
    vecs[3] = '{2'b11, 3'd2, 32'hFFFF_FFFF, 32'd1, 3'd3, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0};
    vecs[4] = '{2'b01, 3'd0, 32'd5, 32'd7, 3'd4, 32'd9, 32'd9, 0, 32'd12, 0};
    vecs[5] = '{2'b10, 3'd0, 32'd0, 32'd0, 3'd1, 32'd1, 32'd4, 1, 32'd16, 0};
    vecs[6] = '{2'b10, 3'd0, 32'd0, 32'd0, 3'd5, 32'h8000_0000, 32'd31, 1, 32'd1, 0};
    vecs[7] = '{2'b10, 3'd0, 32'd0, 32'd0, 3'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1, 32'h0F0F_0F0F, 5};
    vecs[8] = '{2'b11, 3'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd6, 32'h1234_0000, 32'h0000_5678, 0, 32'h0F00_0F00, 2};
    vecs[9] = '{2'b11, 3'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd6, 32'h1234_0000, 32'h0000_5678, 1, 32'h1234_5678, 0};

    repeat (3) @(negedge clock);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_value", rsp_value, 32'd0);
    checkOutput("reset alu_rs1", alu_rs1, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      runTxn($sformatf("vec%0d", i), vecs[i].expG, vecs[i].expV,
             (vecs[i].expG == 0) ? vecs[i].a0 : vecs[i].a1, vecs[i].delay);
    end

    // Reset while the op sits in WAIT: nothing may come back for it.
    v = '{2'b01, 3'd0, 32'd5, 32'd7, 3'd0, 32'd0, 32'd0, 0, 32'd12, 0};
    applyStimulus(v);
    @(negedge clock);
    checkOutput("rst-mid grant", {30'd0, req_ready}, 32'd1);
    @(negedge clock);
    checkOutput("rst-mid issue", {31'd0, alu_enable}, 32'd1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst-mid busy", {31'd0, busy}, 32'd0);
    checkOutput("rst-mid alu_enable", {31'd0, alu_enable}, 32'd0);
    checkOutput("rst-mid req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst-mid rsp_value", rsp_value, 32'd0);
    checkOutput("rst-mid alu_rs1", alu_rs1, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput($sformatf("rst-hold%0d rsp_valid", k), {30'd0, rsp_valid}, 32'd0);
    end
    v = '{2'b11, 3'd0, 32'd1, 32'd2, 3'd0, 32'd10, 32'd20, 0, 32'd3, 0};
    applyStimulus(v);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    runTxn("post-rst", 0, 32'd3, 32'd1, 0);

    // Quiet bus: block must stay idle with nothing asserted.
    v = '{2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 0, 32'd0, 0};
    applyStimulus(v);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checkOutput($sformatf("idle%0d", k), {27'd0, busy, alu_enable, req_ready, rsp_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
